// File: rtl/idc_param_if.sv
// idc_param_if: pixel/op load stream and backpressured output stream of idc_param
interface idc_param_if #(parameter int DATA_W = 7);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic [3:0]               op;
  logic                     out_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;
  modport master (output in_valid, in_data, op, out_ready, input out_valid, out_data, out_last);
  modport slave  (input in_valid, in_data, op, out_ready, output out_valid, out_data, out_last);
endinterface

// File: rtl/idc_param.sv
// idc_param: loads an image and op list, applies ops on a 2x2 window, streams a zoomed quarter view
module idc_param #(
  parameter int IMG_N  = 8,
  parameter int DATA_W = 7,
  parameter int OP_NUM = 15
) (
  input logic        clk,
  input logic        rst,
  idc_param_if.slave bus
);
  localparam int PW = $clog2(IMG_N);
  localparam int AW = 2 * PW;
  localparam int BW = 2 * PW - 2;
  localparam int CW = $clog2(IMG_N * IMG_N + 1);
  localparam int OW = OP_NUM > 1 ? $clog2(OP_NUM) : 1;
  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [PW-1:0] P_RST = PW'(IMG_N / 2 - 1);
  localparam logic [PW-1:0] P_MAX = PW'(IMG_N - 2);
  typedef enum logic [1:0] {IDLE, LOAD, OPER, OUT} state_t;
  state_t state, state_n;
  logic signed [DATA_W-1:0] img [IMG_N*IMG_N];
  logic [3:0] ops [OP_NUM];
  logic [CW-1:0] cnt;
  logic [PW-1:0] pr, pc, pr1, pc1, pr_n, pc_n, row, col;
  logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
  logic signed [DATA_W-1:0] tl, tr, bl, br, n_tl, n_tr, n_bl, n_br;
  logic signed [DATA_W-1:0] mx_t, mx_b, mn_t, mn_b, m1, m2, mid, avg;
  logic signed [DATA_W:0] s1, s1a;
  logic signed [DATA_W+1:0] s2, s2a;
  logic [3:0] cur_op;
  logic [BW-1:0] nidx;
  logic ld, last_ld, last_op, done, zoom, adv;
  function automatic logic signed [DATA_W-1:0] neg(input logic signed [DATA_W-1:0] x);
    return x == SMIN ? SMAX : -x;
  endfunction
  always_comb begin
    ld      = bus.in_valid && (state == IDLE || state == LOAD);
    last_ld = ld && cnt == CW'(IMG_N * IMG_N - 1);
    last_op = state == OPER && cnt == CW'(OP_NUM - 1);
    done    = state == OUT && bus.out_valid && bus.out_ready && bus.out_last;
    state_n = state == IDLE && ld ? LOAD :
              last_ld ? OPER :
              last_op ? OUT :
              done ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    pr1  = pr + PW'(1);
    pc1  = pc + PW'(1);
    a_tl = {pr, pc};
    a_tr = {pr, pc1};
    a_bl = {pr1, pc};
    a_br = {pr1, pc1};
    tl   = img[a_tl];
    tr   = img[a_tr];
    bl   = img[a_bl];
    br   = img[a_br];
    cur_op = ops[OW'(cnt)];
    mx_t = tl > tr ? tl : tr;
    mn_t = tl > tr ? tr : tl;
    mx_b = bl > br ? bl : br;
    mn_b = bl > br ? br : bl;
    m1   = mx_t < mx_b ? mx_t : mx_b;
    m2   = mn_t > mn_b ? mn_t : mn_b;
    s1   = m1 + m2;
    s1a  = s1 + {{DATA_W{1'b0}}, s1[DATA_W]};
    mid  = DATA_W'(s1a >>> 1);
    s2   = tl + tr + bl + br;
    s2a  = s2 + {{DATA_W{1'b0}}, {2{s2[DATA_W+1]}}};
    avg  = DATA_W'(s2a >>> 2);
    n_tl = tl;
    n_tr = tr;
    n_bl = bl;
    n_br = br;
    pr_n = pr;
    pc_n = pc;
    case (cur_op)
      4'd0: {n_tl, n_tr, n_bl, n_br} = {4{mid}};
      4'd1: {n_tl, n_tr, n_bl, n_br} = {4{avg}};
      4'd2: begin n_tl = tr; n_tr = br; n_br = bl; n_bl = tl; end
      4'd3: begin n_tl = bl; n_bl = br; n_br = tr; n_tr = tl; end
      4'd4: begin n_tl = neg(tl); n_tr = neg(tr); n_bl = neg(bl); n_br = neg(br); end
      4'd5: pr_n = pr != '0 ? pr - PW'(1) : pr;
      4'd6: pc_n = pc != '0 ? pc - PW'(1) : pc;
      4'd7: pr_n = pr != P_MAX ? pr1 : pr;
      4'd8: pc_n = pc != P_MAX ? pc1 : pc;
      default: ;
    endcase
    nidx = bus.out_valid ? BW'(cnt + CW'(1)) : '0;
    zoom = !pr[PW-1] && !pc[PW-1];
    row  = zoom ? pr + PW'(nidx[BW-1:PW-1]) + PW'(1) : {nidx[BW-1:PW-1], 1'b0};
    col  = zoom ? pc + PW'(nidx[PW-2:0]) + PW'(1) : {nidx[PW-2:0], 1'b0};
    adv  = state == OUT && (!bus.out_valid || bus.out_ready);
  end
  always_ff @(posedge clk)
    if (!rst && ld) begin
      img[AW'(cnt)] <= bus.in_data;
      if (cnt < CW'(OP_NUM)) ops[OW'(cnt)] <= bus.op;
    end else if (!rst && state == OPER) begin
      img[a_tl] <= n_tl;
      img[a_tr] <= n_tr;
      img[a_bl] <= n_bl;
      img[a_br] <= n_br;
    end
  always_ff @(posedge clk)
    if (rst) begin
      cnt           <= '0;
      pr            <= P_RST;
      pc            <= P_RST;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      if (ld) cnt <= last_ld ? '0 : cnt + CW'(1);
      if (state == OPER) begin
        cnt <= last_op ? '0 : cnt + CW'(1);
        pr  <= pr_n;
        pc  <= pc_n;
      end
      if (adv && bus.out_last) begin
        cnt           <= '0;
        pr            <= P_RST;
        pc            <= P_RST;
        bus.out_valid <= 1'b0;
        bus.out_data  <= '0;
        bus.out_last  <= 1'b0;
      end else if (adv) begin
        cnt           <= bus.out_valid ? cnt + CW'(1) : cnt;
        bus.out_valid <= 1'b1;
        bus.out_data  <= img[{row, col}];
        bus.out_last  <= &nidx;
      end
    end
endmodule
